// File: rtl/updown_gray_counter.sv
// Parametrised up/down counter with a synchronous load, wrap or saturate at the end points,
// and Gray or binary coding on Y. It also exposes the next-state value and the chaining flags.
module updown_gray_counter #(
  parameter int unsigned WIDTH = 3,
  parameter bit          GRAY  = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             EN,
  input  logic             A,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] SF,
  output logic [WIDTH-1:0] SP,
  output logic [WIDTH-1:0] Y,
  output logic             TC,
  output logic             WRAP
);

  logic at_top;
  logic at_bot;

  assign at_top = (SP == '1);
  assign at_bot = (SP == '0);

  always_comb begin
    SF = SP;
    if (reset) begin
      SF = '0;
    end else if (LOAD) begin
      SF = D;
    end else if (EN) begin
      if (A) begin
        if (!(SAT && at_top)) SF = SP + WIDTH'(1);
      end else begin
        if (!(SAT && at_bot)) SF = SP - WIDTH'(1);
      end
    end
  end

  // TC ignores SAT. A saturating counter still reports that it sits at its end point.
  assign TC = EN & ~LOAD & ((A & at_top) | (~A & at_bot));

  always_ff @(posedge CLK) begin
    SP   <= SF;
    WRAP <= ~reset & TC & ~SAT;
  end

  always_comb begin
    if (GRAY) Y = SP ^ (SP >> 1);
    else      Y = SP;
  end

endmodule

// File: tb/tb_updown_gray_counter.sv
// Bench for updown_gray_counter. It drives a 3-bit Gray instance and a 4-bit binary instance
// from the same controls and compares both against an arithmetic model of the counter.
module tb_updown_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, a, sat, load;
  logic [2:0] d3, sf3, sp3, y3;
  logic [3:0] d4, sf4, sp4, y4;
  logic       tc3, wrap3, tc4, wrap4;

  int checks = 0;
  int errors = 0;
  int m3, m4;
  bit valid = 1'b0;

  always #5 clk = ~clk;

  updown_gray_counter #(.WIDTH(3), .GRAY(1'b1)) dut3 (
    .CLK(clk), .reset(rst), .EN(en), .A(a), .SAT(sat), .LOAD(load), .D(d3),
    .SF(sf3), .SP(sp3), .Y(y3), .TC(tc3), .WRAP(wrap3)
  );

  updown_gray_counter #(.WIDTH(4), .GRAY(1'b0)) dut4 (
    .CLK(clk), .reset(rst), .EN(en), .A(a), .SAT(sat), .LOAD(load), .D(d4),
    .SF(sf4), .SP(sp4), .Y(y4), .TC(tc4), .WRAP(wrap4)
  );

  function automatic int model_next(int w, int sp, bit r, bit l, int d, bit e, bit up, bit s);
    int maxv = (1 << w) - 1;
    if (r)   return 0;
    if (l)   return d;
    if (!e)  return sp;
    if (up)  return (s && sp == maxv) ? sp : (sp + 1) % (maxv + 1);
    return (s && sp == 0) ? sp : (sp + maxv) % (maxv + 1);
  endfunction

  function automatic bit model_tc(int w, int sp, bit l, bit e, bit up);
    return e && !l && (up ? (sp == (1 << w) - 1) : (sp == 0));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit up, input bit s, input bit l,
                      input logic [2:0] dv3, input logic [3:0] dv4);
    int  n3, n4;
    bit  t3, t4;
    @(negedge clk);
    rst = r; en = e; a = up; sat = s; load = l; d3 = dv3; d4 = dv4;
    #1;
    if (valid || r) begin
      n3 = model_next(3, m3, r, l, int'(dv3), e, up, s);
      n4 = model_next(4, m4, r, l, int'(dv4), e, up, s);
      chk("sf3", 16'(sf3), 16'(n3));
      chk("sf4", 16'(sf4), 16'(n4));
    end
    if (valid) begin
      t3 = model_tc(3, m3, l, e, up);
      t4 = model_tc(4, m4, l, e, up);
      chk("tc3", 16'(tc3), 16'(t3));
      chk("tc4", 16'(tc4), 16'(t4));
    end
    @(posedge clk);
    #1;
    if (valid || r) begin
      chk("wrap3", 16'(wrap3), (valid && !r && !s && t3) ? 16'd1 : 16'd0);
      chk("wrap4", 16'(wrap4), (valid && !r && !s && t4) ? 16'd1 : 16'd0);
      m3 = n3;
      m4 = n4;
      valid = 1'b1;
      chk("sp3", 16'(sp3), 16'(m3));
      chk("y3",  16'(y3),  16'(m3 ^ (m3 / 2)));
      chk("sp4", 16'(sp4), 16'(m4));
      chk("y4",  16'(y4),  16'(m4));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; sat = 1'b0; load = 1'b0; d3 = '0; d4 = '0;

    // Reset while EN=1 and A=1. The counter must stay at zero.
    step(1, 1, 1, 0, 0, 3'd0, 4'd0);
    step(1, 1, 1, 0, 0, 3'd0, 4'd0);
    chk("reset_sp3", 16'(sp3), 16'd0);

    // Count up and wrap: 9 edges in wrap mode.
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 3'd0, 4'd0);
    chk("upwrap_y3", 16'(y3), 16'b001);

    // Count down through zero, then reverse direction.
    step(0, 1, 1, 0, 1, 3'b010, 4'd2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 3'd0, 4'd0);
    chk("dnwrap_sp3", 16'(sp3), 16'b111);
    step(0, 1, 1, 0, 0, 3'd0, 4'd0);
    chk("dirchg_sp3", 16'(sp3), 16'b000);

    // Saturate at the top, then at the bottom.
    step(0, 1, 1, 1, 1, 3'b110, 4'd14);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 3'd0, 4'd0);
    chk("sat_sp3", 16'(sp3), 16'b111);
    step(0, 1, 0, 1, 1, 3'b000, 4'd0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 0, 3'd0, 4'd0);
    chk("satlo_sp3", 16'(sp3), 16'b000);

    // Load, hold, then reset together with load.
    step(0, 1, 1, 0, 1, 3'b101, 4'b1001);
    chk("load_y3", 16'(y3), 16'b111);
    chk("load_y4", 16'(y4), 16'b1001);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 3'd0, 4'd0);
    chk("hold_sp3", 16'(sp3), 16'b101);
    step(1, 1, 1, 0, 1, 3'b011, 4'b0111);
    chk("rstload_sp3", 16'(sp3), 16'b000);

    // Binary-coded 4-bit instance: wrap from 1110, and a load lands on the top value.
    step(0, 1, 1, 0, 1, 3'b111, 4'b1110);
    step(0, 1, 1, 0, 0, 3'd0, 4'd0);
    chk("bin_y4_top", 16'(y4), 16'b1111);
    step(0, 1, 1, 0, 0, 3'd0, 4'd0);
    chk("bin_wrap4", 16'(wrap4), 16'd1);
    step(0, 1, 1, 0, 1, 3'b111, 4'b1111);
    chk("load_nowrap4", 16'(wrap4), 16'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           3'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_gray_counter.md
Name: updown_gray_counter

Overview:
- Parametrised N-bit up/down state-machine counter with Gray or binary output coding, synchronous load, and selectable wrap or saturate at the end points.
- Generalises the fixed 3-bit single-input counter FSM in the lab series.
- Exposes next state (SF) and present state (SP) for bench observation, plus terminal-count and wrap flags for chaining counters.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- GRAY, 1, output coding on Y: 1 = Gray code of SP, 0 = binary (Y = SP).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- EN  input  1  count enable.
- A  input  1  direction: 1 = count up, 0 = count down.
- SAT  input  1  end-point mode: 1 = saturate, 0 = wrap.
- LOAD  input  1  synchronous load of D.
- D  input  WIDTH  binary load value.
- SF  output  WIDTH  next state (combinational, binary).
- SP  output  WIDTH  present state (registered, binary).
- Y  output  WIDTH  coded output: Gray or binary per GRAY, derived combinationally from SP.
- TC  output  1  terminal count (combinational).
- WRAP  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high; it is sampled only on the rising edge of CLK.
- Reset values: SP = 0, WRAP = 0. Y = 0 follows from SP = 0 in both modes. SF and TC follow the equations below with SP = 0.
- Next-state priority (highest first): reset > LOAD > EN > hold.
  - reset = 1: SF = 0.
  - LOAD = 1: SF = D, regardless of EN, A or SAT.
  - EN = 0: SF = SP.
  - EN = 1, A = 1: SF = SP + 1 modulo 2^WIDTH. If SAT = 1 and SP = all ones, SF = SP.
  - EN = 1, A = 0: SF = SP - 1 modulo 2^WIDTH. If SAT = 1 and SP = 0, SF = SP.
- SP <= SF on every rising edge.
- Latency:
  - Y and TC track SP in the same cycle (zero added latency).
  - A count or load becomes visible on SP/Y one edge after being presented.
- Coding: Gray Y[i] = SP[i] ^ SP[i+1] for i < WIDTH-1; Y[WIDTH-1] = SP[WIDTH-1]. D is always binary; there is no Gray decode on load.
- TC = EN & ~LOAD & ((A & SP == all ones) | (~A & SP == 0)). TC is asserted in both SAT modes.
- WRAP is registered: WRAP <= ~reset & TC & ~SAT. It is high for exactly the one cycle in which SP shows the wrapped value. It is never asserted in saturate mode or on a load.
- Direction change mid-count takes effect on the next edge, with no lost or extra step.
- Reset mid-count: SP = 0 after that edge, WRAP = 0, and any pending wrap is discarded.
- LOAD with D equal to an end value does not raise WRAP.
- Arithmetic is strictly WIDTH bits; there is no carry-out other than TC.

Test Plan (WIDTH=3, GRAY=1 unless stated):
1. Reset: reset=1 for 2 edges with EN=1, A=1 -> SP=000, Y=000, WRAP=0; the counter does not advance while reset=1.
2. Up wrap: reset=0, EN=1, A=1, SAT=0 for 9 edges -> SP 001..111,000,001; Y 001,011,010,110,111,101,100,000,001. TC=1 only while SP=111. WRAP=1 only in the cycle SP=000 after 111.
3. Down wrap and direction change: from SP=010, A=0 for 3 edges -> SP 001,000,111 with WRAP=1 at 111. Then A=1 for 1 edge -> SP=000.
4. Saturate: SAT=1, A=1 from SP=110, 3 edges -> SP 111,111,111 with TC=1 and SF=111 at 111, WRAP=0 throughout. Then A=0, SAT=1 at SP=000 -> holds 000.
5. Load and hold:
   - LOAD=1, D=101, EN=1 -> SP=101, Y=111, TC=0.
   - EN=0 for 3 edges -> SP stays 101.
   - reset=1 and LOAD=1 in the same cycle -> SP=000.
6. Binary mode and width: GRAY=0, WIDTH=4, up count from 1110 -> Y=SP each cycle: 1111 then 0000 with WRAP=1. D=1001 load -> Y=1001.
